// File: rtl/pcs_pg_backpressure_adapter.sv
// pcs_pg_backpressure_adapter
// Turns a valid-only upstream that cannot be stalled into a ready/valid
// (Avalon-ST style) source by buffering symbols in a DEPTH-entry FIFO.
// When the FIFO is full and nothing is popped, the incoming symbol is dropped
// and counted.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high reset
//   in_valid    : upstream symbol present (no ready, cannot be stalled)
//   in_data     : upstream payload
//   out_ready   : downstream accepts the head symbol this cycle
//   out_valid   : out_data holds a buffered symbol
//   out_data    : head-of-buffer payload
//   fill_level  : number of buffered entries, 0..DEPTH
//   overflow    : sticky drop flag
//   drop_count  : saturating count of dropped symbols
//   clr_stats   : synchronous clear of overflow and drop_count
module pcs_pg_backpressure_adapter #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    input  logic                          clr_stats
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pcs_pg_backpressure_adapter: DEPTH must be a power of two in 2..64");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_out_valid;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [FILL_W-1:0]     w_fill_nxt;

    // Handshake decode; a pop frees the slot a same-cycle push writes when full.
    always_comb begin
        w_full = (r_fill == FILL_W'(DEPTH));
        w_pop  = r_out_valid & out_ready;
        w_push = in_valid & (~w_full | w_pop);
        w_drop = in_valid & w_full & ~w_pop;
    end

    // Next fill level.
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + FILL_W'(1);
        end else if (!w_push && w_pop) begin
            w_fill_nxt = r_fill - FILL_W'(1);
        end
    end

    // Payload storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, fill level and registered out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fill      <= w_fill_nxt;
            r_out_valid <= (w_fill_nxt != '0);
        end
    end

    // Drop statistics; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_stats) begin
                r_drop_count <= CNT_WIDTH'(1);
            end else if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end else if (clr_stats) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only notice of every dropped symbol.
    always_ff @(posedge clk) begin
        if (!reset && w_drop) begin
            $display("pcs_pg_backpressure_adapter: symbol 0x%0h dropped at %0t", in_data, $time);
        end
    end
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_mem[r_rd_ptr];
    assign fill_level = r_fill;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pcs_pg_backpressure_adapter.sv
// Directed self-checking bench for pcs_pg_backpressure_adapter
// (DATA_WIDTH=2, DEPTH=4, CNT_WIDTH=8). Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point, reflecting that edge.
module tb_pcs_pg_backpressure_adapter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [2:0] fill_level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_stats;

    int n_checks = 0;
    int n_errors = 0;

    pcs_pg_backpressure_adapter #(
        .DATA_WIDTH (2),
        .DEPTH      (4),
        .CNT_WIDTH  (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_stats  (clr_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] pt_seq [5];
        logic [1:0] fd_seq [5];
        logic [1:0] fs_exp [4];

        pt_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fd_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        fs_exp = '{2'd1, 2'd2, 2'd3, 2'd2};

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd3;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_fill",     32'(fill_level), 32'd0);
        chk("rst_valid",    32'(out_valid),  32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_drops",    32'(drop_count), 32'd0);

        // Pass-through: one-cycle latency, fill level stays 1.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = pt_seq[i];
            step();
            chk("pt_valid", 32'(out_valid),  32'd1);
            chk("pt_data",  32'(out_data),   32'(pt_seq[i]));
            chk("pt_fill",  32'(fill_level), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("pt_empty_valid", 32'(out_valid),  32'd0);
        chk("pt_empty_fill",  32'(fill_level), 32'd0);

        // Fill with stalled output, fifth symbol dropped, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(fd_seq[i]);
        end
        chk("fd_fill",     32'(fill_level), 32'd4);
        chk("fd_overflow", 32'(overflow),   32'd1);
        chk("fd_drops",    32'(drop_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fd_drain_valid", 32'(out_valid), 32'd1);
            chk("fd_drain_data",  32'(out_data),  32'(fd_seq[i]));
            step();
        end
        chk("fd_end_valid", 32'(out_valid),  32'd0);
        chk("fd_end_fill",  32'(fill_level), 32'd0);

        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_overflow", 32'(overflow),   32'd0);
        chk("clr_drops",    32'(drop_count), 32'd0);

        // Full with simultaneous push and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(2'(i));
        end
        chk("fs_fill_pre", 32'(fill_level), 32'd4);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd2;
        step();
        in_valid = 1'b0;
        chk("fs_fill",     32'(fill_level), 32'd4);
        chk("fs_drops",    32'(drop_count), 32'd0);
        chk("fs_overflow", 32'(overflow),   32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("fs_data", 32'(out_data), 32'(fs_exp[i]));
            step();
        end
        chk("fs_end_fill", 32'(fill_level), 32'd0);

        // Stall stability, then ready on an empty buffer has no effect.
        out_ready = 1'b0;
        push(2'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("st_valid", 32'(out_valid),  32'd1);
            chk("st_data",  32'(out_data),   32'd1);
            chk("st_fill",  32'(fill_level), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("st_drained", 32'(fill_level), 32'd0);
        step();
        chk("idle_ready_fill",  32'(fill_level), 32'd0);
        chk("idle_ready_valid", 32'(out_valid),  32'd0);

        // Drop counter saturation and clear behaviour.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(2'd0);
        end
        in_valid = 1'b1;
        in_data  = 2'd3;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        in_valid = 1'b0;
        chk("sat_drops",    32'(drop_count), 32'd255);
        chk("sat_overflow", 32'(overflow),   32'd1);
        chk("sat_fill",     32'(fill_level), 32'd4);
        clr_stats = 1'b1;
        step();
        chk("sat_clr_overflow", 32'(overflow),   32'd0);
        chk("sat_clr_drops",    32'(drop_count), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        clr_stats = 1'b0;
        chk("clr_drop_wins_cnt", 32'(drop_count), 32'd1);
        chk("clr_drop_wins_ovf", 32'(overflow),   32'd1);

        // Reset mid-stream.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("rm_drained", 32'(fill_level), 32'd0);
        out_ready = 1'b0;
        push(2'd1);
        push(2'd2);
        push(2'd3);
        chk("rm_fill_pre", 32'(fill_level), 32'd3);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 2'd0;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rm_fill",     32'(fill_level), 32'd0);
        chk("rm_valid",    32'(out_valid),  32'd0);
        chk("rm_overflow", 32'(overflow),   32'd0);
        push(2'd2);
        chk("rm_post_valid", 32'(out_valid),  32'd1);
        chk("rm_post_data",  32'(out_data),   32'd2);
        chk("rm_post_fill",  32'(fill_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcs_pg_backpressure_adapter.md
PCS_PG_BACKPRESSURE_ADAPTER -- requirements
Module: pcs_pg_backpressure_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 2, width of the payload symbol.
REQ-002 Parameter DEPTH, default 4, buffer entries; SHALL be a power of two, 2..64.
REQ-003 Parameter CNT_WIDTH, default 8, width of the drop counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream symbol present; the upstream has no ready and cannot be stalled.
REQ-007 in_data  input  DATA_WIDTH  upstream payload, sampled when in_valid=1.
REQ-008 out_ready  input  1  downstream accepts the symbol this cycle.
REQ-009 out_valid  output  1  out_data holds a buffered symbol.
REQ-010 out_data  output  DATA_WIDTH  head-of-buffer payload.
REQ-011 fill_level  output  log2(DEPTH)+1  entries currently buffered.
REQ-012 overflow  output  1  sticky; set when a symbol was dropped.
REQ-013 drop_count  output  CNT_WIDTH  number of dropped symbols, saturating.
REQ-014 clr_stats  input  1  synchronous clear of overflow and drop_count.

Function
REQ-015 The block SHALL convert a valid-only, non-backpressurable source into a ready/valid Avalon-ST source through a DEPTH-entry FIFO.
REQ-016 Push: in_valid=1 and (not full or pop this cycle) SHALL write in_data at the write pointer and advance it.
REQ-017 Pop: out_valid=1 and out_ready=1 SHALL retire the head entry and advance the read pointer.
REQ-018 out_valid SHALL equal (fill_level != 0); out_data SHALL come from registered storage, with no combinational path from in_* to out_*.
REQ-019 Latency: a symbol pushed in cycle N SHALL first appear on out_data/out_valid in cycle N+1; no bypass, even when empty.
REQ-020 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Order SHALL be strictly FIFO; no reordering, duplication or loss except under REQ-023.
REQ-022 Simultaneous push and pop SHALL leave fill_level unchanged, including when full (both accepted) and when fill_level=1.
REQ-023 Full with in_valid=1 and no pop: symbol dropped, buffer unchanged, overflow set next cycle, drop_count incremented.
REQ-024 drop_count SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-025 clr_stats=1 SHALL clear overflow and drop_count next cycle; a drop in the same cycle as clr_stats SHALL win (overflow=1, drop_count=1).
REQ-026 Pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; fill_level SHALL range 0..DEPTH.
REQ-027 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-028 Simulation-only check SHALL report any drop via $display; excluded from synthesis.

Reset
REQ-029 reset=1 SHALL, at the next rising edge, set pointers=0, fill_level=0, out_valid=0, overflow=0, drop_count=0; storage contents need not be cleared.
REQ-030 reset SHALL take priority over push, pop and clr_stats; symbols presented during reset SHALL be discarded.
REQ-031 Reset mid-operation SHALL discard all buffered symbols; first symbol after reset release appears at N+1 per REQ-019.
REQ-032 out_data value while out_valid=0 is don't-care.

Verification
REQ-033 Pass-through: out_ready=1, in_valid=1 with data 0,1,2,3,0 on cycles 1..5 -> out_valid=1 cycles 2..6, out_data 0,1,2,3,0, fill_level stays 1.
REQ-034 Fill and drain: out_ready=0, push 3,2,1,0,3 -> fill_level 4, overflow=1, drop_count=1; then out_ready=1 -> out_data 3,2,1,0, fifth symbol never appears.
REQ-035 Full with simultaneous push/pop: fill_level=4, out_ready=1, in_valid=1 data 2 -> no drop, fill_level stays 4, 2 emerges after the 4 older entries.
REQ-036 Stall stability: out_valid=1 data 1, out_ready=0 for 10 cycles -> out_data=1 every cycle, fill_level unchanged.
REQ-037 Saturation and clear: CNT_WIDTH=8, 300 drops -> drop_count=255; clr_stats=1 with no drop -> overflow=0, drop_count=0 next cycle; clr_stats with concurrent drop -> drop_count=1.
REQ-038 Reset mid-stream: fill_level=3, assert reset one cycle -> fill_level=0, out_valid=0, overflow=0 next cycle; next push emerges one cycle later.
